byte_serial_add_ctrl: RTL



---
 rtl/bsa_pkg.sv | 22 ++
 rtl/eight_bitadder.sv | 32 +++
 rtl/byte_serial_add_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bsa_pkg.sv
// rtl/bsa_pkg.sv - shared state encodings and slice constants for the byte-serial adder
//
// Purpose : common definitions imported by byte_serial_add_ctrl.
// Contents: state_t (ST_IDLE/ST_RUN/ST_DONE), SLICE_W, idx_bits() helper.
package bsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the shared adder slice; eight_bitadder is built for exactly this.
  localparam int SLICE_W = 8;

  // Bits needed to count n passes. A single-pass build still gets a 1-bit
  // index so the register never collapses to zero width.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eight_bitadder.sv
// rtl/eight_bitadder.sv - combinational 8-bit ripple-carry adder slice
//
// Purpose : one adder pass for the byte-serial controller.
// Ports   : a, b    in  8  addends
//           cin     in  1  carry into bit 0
//           sum     out 8  a + b + cin (low 8 bits)
//           cout    out 1  carry out of bit 7
module eight_bitadder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  // Explicit full-adder chain so the slice maps onto the same ripple cell
  // as the unrolled 32-bit adder it replaces.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout = c[8];

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// rtl/byte_serial_add_ctrl.sv - WIDTH-bit adder time-multiplexed over one 8-bit slice
//
// Purpose : accepts operands on a valid/ready handshake, adds them LSB slice
//           first over WIDTH/8 cycles with a registered carry, and returns the
//           result on a second valid/ready handshake.
// Ports   : clk          in  1      rising-edge clock
//           rst          in  1      synchronous active-high reset
//           start_valid  in  1      a, b, cin (and sub) are valid
//           start_ready  out 1      controller can accept operands (IDLE only)
//           sub          in  1      subtract mode, only with BSA_SUB_EN defined
//           a, b         in  WIDTH  addends
//           cin          in  1      carry into slice 0
//           res_valid    out 1      sum/cout valid
//           res_ready    in  1      consumer accepts result
//           sum          out WIDTH  registered result
//           cout         out 1      carry out of the top slice
//           busy         out 1      high in RUN or DONE
// Config  : define BSA_SUB_EN to add the sub port (a - b, cout=1 means no borrow).
module byte_serial_add_ctrl
  import bsa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
`ifdef BSA_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = idx_bits(NSLICE);
  localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0 || WIDTH < SLICE || SLICE != SLICE_W) begin : g_bad_width
    $error("byte_serial_add_ctrl: WIDTH must be a non-zero multiple of the 8-bit slice");
  end

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry;
  logic [IDXW-1:0]   idx;

  logic [BW-1:0]     base;
  logic [SLICE-1:0]  slice_a;
  logic [SLICE-1:0]  slice_b;
  logic [SLICE-1:0]  slice_sum;
  logic              slice_cout;

  // Operand conditioning at accept time. In subtract mode b is stored
  // inverted and the carry seeded with 1, so RUN is identical for both modes.
  logic [WIDTH-1:0]  b_in;
  logic              carry_in;

`ifdef BSA_SUB_EN
  assign b_in     = sub ? ~b : b;
  assign carry_in = sub ? 1'b1 : cin;
`else
  assign b_in     = b;
  assign carry_in = cin;
`endif

  // Bit offset of the current slice: idx * SLICE.
  assign base    = BW'(idx) << $clog2(SLICE);
  assign slice_a = a_q[base +: SLICE];
  assign slice_b = b_q[base +: SLICE];

  eight_bitadder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Handshake qualifiers are forced low during reset so nothing upstream
  // sees a ready while the FSM is being cleared.
  assign start_ready = !rst && (state == ST_IDLE);
  assign busy        = !rst && ((state == ST_RUN) || (state == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            a_q   <= a;
            b_q   <= b_in;
            carry <= carry_in;
            idx   <= '0;
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Slices not yet reached keep the previous result.
          sum[base +: SLICE] <= slice_sum;
          carry              <= slice_cout;
          if (idx == LAST_IDX) begin
            cout      <= slice_cout;
            res_valid <= 1'b1;
            idx       <= '0;
            state     <= ST_DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end

        ST_DONE: begin
          // sum/cout are left untouched on handoff and stay readable.
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          res_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
